instr_fetch_unit: RTL

- Parametrised instruction fetch stage for the KGP-RISC core. Owns the PC register, a word-addressed synchronous instruction memory with a program-load port, and a prefetch FIFO. Drives a valid/ready handshake toward decode.
- Supports branch/jump redirect with flush, and back-pressure stall.
- Replaces the bare pc-in/instruction-out fetch block: the PC is now internal and auto-incrementing.

---
 rtl/instr_fetch_unit.sv | 126 ++++++++++++
 1 files changed

// File: rtl/instr_fetch_unit.sv
// KGP-RISC fetch stage: internal auto-incrementing PC, synchronous instruction RAM
// with a program-load port, and a credit-controlled prefetch FIFO feeding decode.
module instr_fetch_unit #(
  parameter int ADDR_WIDTH  = 32,
  parameter int INSTR_WIDTH = 32,
  parameter int MEM_DEPTH   = 256,
  parameter int BUF_DEPTH   = 4,
  parameter logic [ADDR_WIDTH-1:0] RESET_PC = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   load_en,
  input  logic [ADDR_WIDTH-1:0]  load_addr,
  input  logic [INSTR_WIDTH-1:0] load_data,
  input  logic                   redirect_valid,
  input  logic [ADDR_WIDTH-1:0]  redirect_pc,
  input  logic                   out_ready,
  output logic                   out_valid,
  output logic [INSTR_WIDTH-1:0] out_instr,
  output logic [ADDR_WIDTH-1:0]  out_pc,
  output logic                   out_fault
);

  localparam int MEM_AW = $clog2(MEM_DEPTH);
  localparam int PTR_W  = $clog2(BUF_DEPTH);
  localparam logic [ADDR_WIDTH:0] MEM_LIMIT = (ADDR_WIDTH+1)'(MEM_DEPTH);
  localparam logic [PTR_W+1:0]    BUF_LIMIT = (PTR_W+2)'(BUF_DEPTH);

  logic [INSTR_WIDTH-1:0] mem [MEM_DEPTH];
  logic [INSTR_WIDTH-1:0] rdata_q;

  logic [ADDR_WIDTH-1:0]  fetch_pc_q, fetch_pc_d;
  logic                   inflight_q, inflight_d;
  logic [ADDR_WIDTH-1:0]  inflight_pc_q;
  logic                   inflight_fault_q;

  logic [INSTR_WIDTH-1:0] fifo_instr_q [BUF_DEPTH];
  logic [ADDR_WIDTH-1:0]  fifo_pc_q    [BUF_DEPTH];
  logic                   fifo_fault_q [BUF_DEPTH];
  logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
  logic [PTR_W:0]         count_q, count_d;

  logic                   pop;
  logic                   push;
  logic                   issue;
  logic                   fetch_fault;
  logic [PTR_W+1:0]       credit;
  logic [INSTR_WIDTH-1:0] push_instr;

  // A slot is reserved for every in-flight read so a response can never overflow the FIFO.
  always_comb begin
    pop         = (count_q != '0) && out_ready;
    credit      = {1'b0, count_q} + (PTR_W+2)'(inflight_q) - (PTR_W+2)'(pop);
    issue       = !rst && !redirect_valid && (credit < BUF_LIMIT);
    push        = inflight_q && !redirect_valid;
    fetch_fault = {1'b0, fetch_pc_q} >= MEM_LIMIT;
    push_instr  = inflight_fault_q ? '0 : rdata_q;
  end

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    inflight_d = inflight_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    if (redirect_valid) begin
      fetch_pc_d = redirect_pc;
      inflight_d = 1'b0;
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      count_d    = '0;
    end else begin
      inflight_d = issue;
      if (issue) fetch_pc_d = fetch_pc_q + ADDR_WIDTH'(1);
      if (push)  wr_ptr_d   = wr_ptr_q + PTR_W'(1);
      if (pop)   rd_ptr_d   = rd_ptr_q + PTR_W'(1);
      count_d = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      fetch_pc_q <= RESET_PC;
      inflight_q <= 1'b0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      inflight_q <= inflight_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
    end
  end

  // Memory has no reset so it can map onto block RAM; the registered read sees pre-write data.
  always_ff @(posedge clk) begin
    if (load_en && !rst) mem[load_addr[MEM_AW-1:0]] <= load_data;
    if (issue) begin
      rdata_q          <= mem[fetch_pc_q[MEM_AW-1:0]];
      inflight_pc_q    <= fetch_pc_q;
      inflight_fault_q <= fetch_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !rst) begin
      fifo_instr_q[wr_ptr_q] <= push_instr;
      fifo_pc_q[wr_ptr_q]    <= inflight_pc_q;
      fifo_fault_q[wr_ptr_q] <= inflight_fault_q;
    end
  end

  assign out_valid = (count_q != '0);
  assign out_instr = out_valid ? fifo_instr_q[rd_ptr_q] : '0;
  assign out_pc    = out_valid ? fifo_pc_q[rd_ptr_q]    : '0;
  assign out_fault = out_valid ? fifo_fault_q[rd_ptr_q] : 1'b0;

  if (ADDR_WIDTH > MEM_AW) begin : g_addr_hi
    logic unused_load_addr_hi;
    assign unused_load_addr_hi = ^load_addr[ADDR_WIDTH-1:MEM_AW];
  end

endmodule
